multi_hand_datapath: RTL and testbench

Parametrised successor to the two-hand baccarat datapath. It holds NUM_HANDS hands of up to CARDS_PER_HAND cards, with a free-running card generator and per-hand slot pointers. Each hand has a registered modulo-SCORE_MOD running score, and a req/ack deal handshake replaces the per-slot load strobes. It sits between the game-control FSM and the score/display logic, in the single fast_clock domain.

---
 rtl/multi_hand_datapath.sv | 106 ++++++++++
 tb/tb_multi_hand_datapath.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_hand_datapath.sv
// multi_hand_datapath: multi-hand card store with free-running rank generator, modulo scores and req/ack deal handshake
module multi_hand_datapath #(
  parameter int NUM_HANDS = 2,
  parameter int CARDS_PER_HAND = 3,
  parameter int SCORE_MOD = 10,
  localparam int HSEL_W = NUM_HANDS > 1 ? $clog2(NUM_HANDS) : 1,
  localparam int CNT_W = $clog2(CARDS_PER_HAND + 1),
  localparam int SCORE_W = $clog2(SCORE_MOD)
) (
  input  logic fast_clock,
  input  logic reset,
  input  logic deal_req,
  input  logic [HSEL_W-1:0] hand_sel,
  input  logic inject_en,
  input  logic [3:0] inject_card,
  input  logic [NUM_HANDS-1:0] clear_hand,
  output logic busy,
  output logic deal_ack,
  output logic deal_err,
  output logic [NUM_HANDS*CARDS_PER_HAND*4-1:0] cards_out,
  output logic [NUM_HANDS*CNT_W-1:0] card_count,
  output logic [NUM_HANDS*SCORE_W-1:0] scores,
  output logic [NUM_HANDS-1:0] hand_full
);
  typedef enum logic [1:0] {IDLE, LOAD, SCORE, DONE} state_t;
  localparam logic [SCORE_W:0] MOD = (SCORE_W+1)'(SCORE_MOD);
  state_t state, state_n;
  logic [3:0] gen, rank, rank_in, value;
  logic [HSEL_W-1:0] h_q;
  logic err, take, req_err;
  logic [3:0] card [NUM_HANDS][CARDS_PER_HAND];
  logic [CNT_W-1:0] count [NUM_HANDS];
  logic [SCORE_W-1:0] score [NUM_HANDS];
  logic [SCORE_W-1:0] sel_score, score_n;
  logic [SCORE_W:0] sum;
  logic [2**HSEL_W-1:0] bad;
  genvar i, s;
  // selector codes beyond NUM_HANDS are treated like a full hand so one lookup covers both errors
  for (i = 0; i < 2**HSEL_W; i++) begin : g_bad
    if (i < NUM_HANDS) begin : g_v
      assign bad[i] = hand_full[i];
    end else begin : g_x
      assign bad[i] = 1'b1;
    end
  end
  for (i = 0; i < NUM_HANDS; i++) begin : g_out
    assign card_count[i*CNT_W +: CNT_W] = count[i];
    assign scores[i*SCORE_W +: SCORE_W] = score[i];
    assign hand_full[i] = count[i] == CNT_W'(CARDS_PER_HAND);
    for (s = 0; s < CARDS_PER_HAND; s++) begin : g_slot
      assign cards_out[(i*CARDS_PER_HAND+s)*4 +: 4] = card[i][s];
    end
  end
  assign take = state == IDLE && deal_req && clear_hand == '0;
  assign rank_in = inject_en ? inject_card : gen;
  assign req_err = bad[hand_sel] || rank_in == 4'd0 || rank_in > 4'd13;
  assign busy = state != IDLE;
  assign deal_ack = state == DONE;
  assign deal_err = deal_ack && err;
  always_comb begin
    sel_score = '0;
    for (int h = 0; h < NUM_HANDS; h++)
      if (h_q == HSEL_W'(h)) sel_score = score[h];
    value = rank <= 4'd9 ? rank : 4'd0;
    sum = {1'b0, sel_score} + (SCORE_W+1)'(value);
    score_n = SCORE_W'(sum >= MOD ? sum - MOD : sum);
    state_n = state == IDLE ? (take ? (req_err ? DONE : LOAD) : IDLE) :
              state == LOAD ? SCORE : state == SCORE ? DONE : IDLE;
  end
  always_ff @(posedge fast_clock)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge fast_clock) begin
    if (reset) begin
      gen <= 4'd1;
      rank <= '0;
      h_q <= '0;
      err <= 1'b0;
      for (int h = 0; h < NUM_HANDS; h++) begin
        count[h] <= '0;
        score[h] <= '0;
        for (int k = 0; k < CARDS_PER_HAND; k++) card[h][k] <= '0;
      end
    end else begin
      gen <= gen == 4'd13 ? 4'd1 : gen + 4'd1;
      if (take) begin
        rank <= rank_in;
        h_q <= hand_sel;
        err <= req_err;
      end
      for (int h = 0; h < NUM_HANDS; h++) begin
        if (state == IDLE && clear_hand[h]) begin
          count[h] <= '0;
          score[h] <= '0;
          for (int k = 0; k < CARDS_PER_HAND; k++) card[h][k] <= '0;
        end
        if (state == LOAD && h_q == HSEL_W'(h)) begin
          for (int k = 0; k < CARDS_PER_HAND; k++)
            if (count[h] == CNT_W'(k)) card[h][k] <= rank;
          count[h] <= count[h] + 1'b1;
        end
        if (state == SCORE && h_q == HSEL_W'(h)) score[h] <= score_n;
      end
    end
  end
endmodule

// File: tb/tb_multi_hand_datapath.sv
// tb_multi_hand_datapath: directed vector bench for default and wider-parameter datapath instances
module tb_multi_hand_datapath;
  logic fast_clock = 0, reset = 1;
  logic deal_req = 0, hand_sel = 0, inject_en = 0;
  logic [3:0] inject_card = 0;
  logic [1:0] clear_hand = 0;
  logic busy, deal_ack, deal_err;
  logic [23:0] cards_out;
  logic [3:0] card_count;
  logic [7:0] scores;
  logic [1:0] hand_full;
  logic b_req = 0, b_ie = 0;
  logic [1:0] b_sel = 0;
  logic [3:0] b_card = 0;
  logic [2:0] b_clear = 0;
  logic b_busy, b_ack, b_err;
  logic [59:0] b_cards;
  logic [8:0] b_count;
  logic [11:0] b_scores;
  logic [2:0] b_full;
  int n_cmp = 0, n_bad = 0;
  logic [3:0] mgen;

  always #5 fast_clock = ~fast_clock;
  always @(posedge fast_clock) mgen <= reset ? 4'd1 : (mgen == 4'd13 ? 4'd1 : mgen + 4'd1);

  multi_hand_datapath dut (
    .fast_clock(fast_clock), .reset(reset), .deal_req(deal_req), .hand_sel(hand_sel),
    .inject_en(inject_en), .inject_card(inject_card), .clear_hand(clear_hand),
    .busy(busy), .deal_ack(deal_ack), .deal_err(deal_err), .cards_out(cards_out),
    .card_count(card_count), .scores(scores), .hand_full(hand_full));

  multi_hand_datapath #(.NUM_HANDS(3), .CARDS_PER_HAND(5), .SCORE_MOD(12)) dut_b (
    .fast_clock(fast_clock), .reset(reset), .deal_req(b_req), .hand_sel(b_sel),
    .inject_en(b_ie), .inject_card(b_card), .clear_hand(b_clear),
    .busy(b_busy), .deal_ack(b_ack), .deal_err(b_err), .cards_out(b_cards),
    .card_count(b_count), .scores(b_scores), .hand_full(b_full));

  typedef struct {
    logic h; logic ie; logic [3:0] c; logic e; int lat; int s; int n;
  } vec_t;
  vec_t v [8];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int cnt_a(input int h); return int'(card_count[h*2 +: 2]); endfunction
  function automatic int sc_a(input int h); return int'(scores[h*4 +: 4]); endfunction
  function automatic int slot_a(input int h, input int k); return int'(cards_out[(h*3+k)*4 +: 4]); endfunction

  task automatic deal(input logic h, input logic ie, input logic [3:0] c,
                      output int lat, output logic e, output int r);
    @(negedge fast_clock);
    deal_req = 1; hand_sel = h; inject_en = ie; inject_card = c; r = int'(mgen);
    @(negedge fast_clock);
    deal_req = 0; inject_en = 0;
    lat = 0; e = 0;
    for (int i = 1; i <= 10 && lat == 0; i++)
      if (deal_ack) begin lat = i; e = deal_err; end
      else @(negedge fast_clock);
  endtask

  task automatic deal_b(input logic [1:0] h, input logic [3:0] c, output int lat, output logic e);
    @(negedge fast_clock);
    b_req = 1; b_sel = h; b_ie = 1; b_card = c;
    @(negedge fast_clock);
    b_req = 0; b_ie = 0;
    lat = 0; e = 0;
    for (int i = 1; i <= 10 && lat == 0; i++)
      if (b_ack) begin lat = i; e = b_err; end
      else @(negedge fast_clock);
  endtask

  task automatic pulse_reset();
    @(negedge fast_clock); reset = 1;
    @(negedge fast_clock);
    @(negedge fast_clock); reset = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat, r, seen, c;
    logic e;
    int bs [5] = '{9, 6, 3, 0, 9};
    v[0] = '{1'b0, 1'b1, 4'd7,  1'b0, 3, 7, 1};
    v[1] = '{1'b0, 1'b1, 4'd8,  1'b0, 3, 5, 2};
    v[2] = '{1'b0, 1'b1, 4'd13, 1'b0, 3, 5, 3};
    v[3] = '{1'b0, 1'b1, 4'd5,  1'b1, 1, 5, 3};
    v[4] = '{1'b1, 1'b1, 4'd0,  1'b1, 1, 0, 0};
    v[5] = '{1'b1, 1'b1, 4'd14, 1'b1, 1, 0, 0};
    v[6] = '{1'b1, 1'b1, 4'd9,  1'b0, 3, 9, 1};
    v[7] = '{1'b1, 1'b1, 4'd9,  1'b0, 3, 8, 2};

    repeat (2) @(negedge fast_clock);
    reset = 0;
    deal(1'b0, 1'b1, 4'd7, lat, e, r);
    chk("pre_reset_lat", lat, 3);
    pulse_reset();
    chk("rst_cards", int'(cards_out != 0), 0);
    chk("rst_count", int'(card_count), 0);
    chk("rst_scores", int'(scores), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ack", int'(deal_ack), 0);
    chk("rst_full", int'(hand_full), 0);
    chk("rst_b_state", int'(b_cards != 0 || b_count != 0 || b_scores != 0 || b_busy), 0);

    deal(1'b1, 1'b0, 4'd0, lat, e, r);
    c = slot_a(1, 0);
    chk("first_gen_rank", c, r);
    chk("first_gen_range", int'(c >= 1 && c <= 13), 1);
    @(negedge fast_clock); clear_hand = 2'b10;
    @(negedge fast_clock); clear_hand = 2'b00;
    chk("clear_h1_count", cnt_a(1), 0);
    chk("clear_h1_slot0", slot_a(1, 0), 0);

    foreach (v[i]) begin
      deal(v[i].h, v[i].ie, v[i].c, lat, e, r);
      chk($sformatf("vec%0d_lat", i), lat, v[i].lat);
      chk($sformatf("vec%0d_err", i), int'(e), int'(v[i].e));
      chk($sformatf("vec%0d_score", i), sc_a(int'(v[i].h)), v[i].s);
      chk($sformatf("vec%0d_count", i), cnt_a(int'(v[i].h)), v[i].n);
    end
    chk("h0_cards", int'(cards_out[11:0]), 'hD87);
    chk("h0_full", int'(hand_full[0]), 1);
    chk("h1_cards", int'(cards_out[23:12]), 'h099);

    @(negedge fast_clock);
    clear_hand = 2'b10; deal_req = 1; hand_sel = 1; inject_en = 1; inject_card = 4'd5;
    @(negedge fast_clock);
    clear_hand = 2'b00; deal_req = 0; inject_en = 0;
    chk("clr_pri_count1", cnt_a(1), 0);
    chk("clr_pri_score1", sc_a(1), 0);
    chk("clr_pri_cards1", int'(cards_out[23:12]), 0);
    chk("clr_pri_busy", int'(busy), 0);
    chk("clr_pri_h0_count", cnt_a(0), 3);
    chk("clr_pri_h0_score", sc_a(0), 5);
    seen = 0;
    repeat (4) begin @(negedge fast_clock); seen |= int'(deal_ack); end
    chk("clr_pri_no_ack", seen, 0);

    clear_hand = 2'b01;
    @(negedge fast_clock); clear_hand = 2'b00;
    deal_req = 1; hand_sel = 0; inject_en = 1; inject_card = 4'd4;
    @(negedge fast_clock);
    hand_sel = 1; inject_card = 4'd6;
    @(negedge fast_clock);
    deal_req = 0; inject_en = 0;
    lat = 0;
    for (int i = 2; i <= 10 && lat == 0; i++)
      if (deal_ack) lat = i; else @(negedge fast_clock);
    chk("gate_lat", lat, 3);
    chk("gate_h0_count", cnt_a(0), 1);
    chk("gate_h0_score", sc_a(0), 4);
    @(negedge fast_clock);
    chk("gate_ack_one_cycle", int'(deal_ack), 0);
    repeat (2) @(negedge fast_clock);
    chk("gate_h1_count", cnt_a(1), 0);
    chk("gate_busy", int'(busy), 0);

    deal_req = 1; hand_sel = 0; inject_en = 1; inject_card = 4'd3;
    @(negedge fast_clock);
    deal_req = 0; inject_en = 0;
    @(negedge fast_clock);
    chk("abort_in_score", int'(busy), 1);
    reset = 1;
    @(negedge fast_clock);
    reset = 0;
    chk("abort_ack", int'(deal_ack), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_count", int'(card_count), 0);
    chk("abort_scores", int'(scores), 0);
    chk("abort_cards", int'(cards_out != 0), 0);
    seen = 0;
    repeat (4) begin @(negedge fast_clock); seen |= int'(deal_ack); end
    chk("abort_no_late_ack", seen, 0);

    for (int j = 0; j < 6; j++) begin
      repeat (j) @(negedge fast_clock);
      deal(j >= 3, 1'b0, 4'd0, lat, e, r);
      c = slot_a(j >= 3 ? 1 : 0, j % 3);
      chk($sformatf("gen%0d_rank", j), c, r);
      chk($sformatf("gen%0d_range", j), int'(c >= 1 && c <= 13), 1);
      chk($sformatf("gen%0d_err", j), int'(e), 0);
    end

    for (int j = 0; j < 5; j++) begin
      deal_b(2'd0, 4'd9, lat, e);
      chk($sformatf("b%0d_lat", j), lat, 3);
      chk($sformatf("b%0d_score", j), int'(b_scores[3:0]), bs[j]);
      chk($sformatf("b%0d_count", j), int'(b_count[2:0]), j + 1);
      chk($sformatf("b%0d_full", j), int'(b_full[0]), int'(j == 4));
    end
    deal_b(2'd0, 4'd9, lat, e);
    chk("b_over_lat", lat, 1);
    chk("b_over_err", int'(e), 1);
    chk("b_over_score", int'(b_scores[3:0]), 9);
    deal_b(2'd3, 4'd2, lat, e);
    chk("b_badsel_lat", lat, 1);
    chk("b_badsel_err", int'(e), 1);
    chk("b_badsel_others", int'(b_count[8:3]), 0);
    chk("b_cards", int'(b_cards[19:0] == 20'h99999), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
